tpm_buf_arbiter: RTL and testbench

//  Single-clock arbiter for the shared 512x32 TPM command/response buffer RAM.

---
 rtl/tpm_buf_arbiter_if.sv | 48 ++++
 rtl/tpm_buf_arbiter.sv | 145 ++++++++++++++
 tb/tb_tpm_buf_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpm_buf_arbiter_if.sv
// Bus bundle for tpm_buf_arbiter: the DP byte port, the Wishbone word port and
// the RAM access port. Signal suffixes are given from the arbiter's point of view.
//   slave  modport: used by the arbiter
//   master modport: used by the requesters and the RAM model that surround the arbiter
interface tpm_buf_arbiter_if #(
    parameter int unsigned RAM_ADDR_WIDTH = 11
) ();
    // LPC data provider, byte port
    logic                        dp_req_i;
    logic                        dp_we_i;
    logic [RAM_ADDR_WIDTH-1:0]   dp_addr_i;
    logic [7:0]                  dp_data_i;
    logic [7:0]                  dp_data_o;
    logic                        dp_ack_o;
    logic                        dp_err_o;
    // M4 Wishbone slave, word port
    logic                        wb_cyc_i;
    logic                        wb_stb_i;
    logic                        wb_we_i;
    logic [RAM_ADDR_WIDTH-3:0]   wb_adr_i;
    logic [3:0]                  wb_sel_i;
    logic [31:0]                 wb_dat_i;
    logic [31:0]                 wb_dat_o;
    logic                        wb_ack_o;
    // Shared buffer RAM
    logic [RAM_ADDR_WIDTH-3:0]   ram_addr_o;
    logic [31:0]                 ram_wd_o;
    logic [3:0]                  ram_wen_o;
    logic [31:0]                 ram_rd_i;

    modport slave (
        input  dp_req_i, dp_we_i, dp_addr_i, dp_data_i,
        output dp_data_o, dp_ack_o, dp_err_o,
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o,
        output ram_addr_o, ram_wd_o, ram_wen_o,
        input  ram_rd_i
    );

    modport master (
        output dp_req_i, dp_we_i, dp_addr_i, dp_data_i,
        input  dp_data_o, dp_ack_o, dp_err_o,
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o,
        input  ram_addr_o, ram_wd_o, ram_wen_o,
        output ram_rd_i
    );
endinterface

// File: rtl/tpm_buf_arbiter.sv
// Round-robin arbiter for the shared 512x32 TPM command/response buffer RAM.
// Serves the LPC data provider (byte port) and the M4 Wishbone slave (word port)
// through one sequenced access path: IDLE (sample + capture) -> ACCESS (RAM
// samples addr/data/wen) -> RESP (ack pulse, read data from RAM).
// While exec_i is sampled high, DP accesses are rejected: no RAM write, dp_err_o
// with the ack and LOCK_READ_VALUE returned for reads.
// Ports:
//   clk_i   single clock, RAM is clocked by it too
//   nrst_i  asynchronous reset, active low
//   exec_i  1 = buffer owned by the M4
//   bus     slave side of tpm_buf_arbiter_if (DP port, WB port, RAM port)
module tpm_buf_arbiter #(
    parameter int unsigned RAM_ADDR_WIDTH  = 11,
    parameter logic [7:0]  LOCK_READ_VALUE = 8'hFF
) (
    input logic                 clk_i,
    input logic                 nrst_i,
    input logic                 exec_i,
    tpm_buf_arbiter_if.slave    bus
);

    localparam int unsigned WordAw = RAM_ADDR_WIDTH - 2;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic                last_wb_q, last_wb_d;  // 1 = WB was granted last
    logic                gnt_wb_q, gnt_wb_d;    // side owning the current access
    logic                lock_q, lock_d;        // exec_i captured for a DP access
    logic [1:0]          lane_q, lane_d;        // DP byte lane within the word
    logic [WordAw-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wd_q, ram_wd_d;
    logic [3:0]          ram_wen_q, ram_wen_d;
    logic                dp_ack_q, dp_ack_d;
    logic                dp_err_q, dp_err_d;
    logic                wb_ack_q, wb_ack_d;

    logic                dp_req;
    logic                wb_req;
    logic                grant_wb;

    assign dp_req = bus.dp_req_i;
    assign wb_req = bus.wb_cyc_i & bus.wb_stb_i;

    always_comb begin
        state_d    = state_q;
        last_wb_d  = last_wb_q;
        gnt_wb_d   = gnt_wb_q;
        lock_d     = lock_q;
        lane_d     = lane_q;
        ram_addr_d = ram_addr_q;
        ram_wd_d   = ram_wd_q;
        ram_wen_d  = 4'b0000;
        dp_ack_d   = 1'b0;
        dp_err_d   = 1'b0;
        wb_ack_d   = 1'b0;
        grant_wb   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dp_req || wb_req) begin
                    // On a tie the side that did not win last time gets the buffer
                    grant_wb  = wb_req && (!dp_req || !last_wb_q);
                    gnt_wb_d  = grant_wb;
                    last_wb_d = grant_wb;
                    state_d   = StAccess;
                    if (grant_wb) begin
                        ram_addr_d = bus.wb_adr_i;
                        ram_wd_d   = bus.wb_dat_i;
                        ram_wen_d  = bus.wb_we_i ? bus.wb_sel_i : 4'b0000;
                        lock_d     = 1'b0;
                    end else begin
                        ram_addr_d = bus.dp_addr_i[RAM_ADDR_WIDTH-1:2];
                        ram_wd_d   = {4{bus.dp_data_i}};
                        lane_d     = bus.dp_addr_i[1:0];
                        lock_d     = exec_i;
                        ram_wen_d  = (bus.dp_we_i && !exec_i) ?
                                     (4'b0001 << bus.dp_addr_i[1:0]) : 4'b0000;
                    end
                end
            end
            StAccess: begin
                state_d  = StResp;
                dp_ack_d = !gnt_wb_q;
                dp_err_d = !gnt_wb_q && lock_q;
                wb_ack_d = gnt_wb_q;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q    <= StIdle;
            last_wb_q  <= 1'b1;
            gnt_wb_q   <= 1'b0;
            lock_q     <= 1'b0;
            lane_q     <= 2'b00;
            ram_addr_q <= '0;
            ram_wd_q   <= 32'h0;
            ram_wen_q  <= 4'b0000;
            dp_ack_q   <= 1'b0;
            dp_err_q   <= 1'b0;
            wb_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_wb_q  <= last_wb_d;
            gnt_wb_q   <= gnt_wb_d;
            lock_q     <= lock_d;
            lane_q     <= lane_d;
            ram_addr_q <= ram_addr_d;
            ram_wd_q   <= ram_wd_d;
            ram_wen_q  <= ram_wen_d;
            dp_ack_q   <= dp_ack_d;
            dp_err_q   <= dp_err_d;
            wb_ack_q   <= wb_ack_d;
        end
    end

    // RAM read data arrives during RESP, so the data outputs are steered from
    // ram_rd_i directly and forced to zero outside the ack cycle.
    always_comb begin
        bus.dp_data_o = 8'h00;
        bus.wb_dat_o  = 32'h0;
        if (dp_ack_q) begin
            bus.dp_data_o = lock_q ? LOCK_READ_VALUE : bus.ram_rd_i[{lane_q, 3'b000} +: 8];
        end
        if (wb_ack_q) begin
            bus.wb_dat_o = bus.ram_rd_i;
        end
    end

    assign bus.dp_ack_o   = dp_ack_q;
    assign bus.dp_err_o   = dp_err_q;
    assign bus.wb_ack_o   = wb_ack_q;
    assign bus.ram_addr_o = ram_addr_q;
    assign bus.ram_wd_o   = ram_wd_q;
    assign bus.ram_wen_o  = ram_wen_q;

endmodule

// File: tb/tb_tpm_buf_arbiter.sv
// Testbench for tpm_buf_arbiter: byte-addressed shadow model with round-robin
// order prediction, per-requester expectation queues and an ack-driven monitor.
module tb_tpm_buf_arbiter;

    localparam int unsigned AW = 11;

    logic clk_i = 1'b0;
    logic nrst_i;
    logic exec_i;

    tpm_buf_arbiter_if #(.RAM_ADDR_WIDTH(AW)) arb_if ();

    tpm_buf_arbiter #(
        .RAM_ADDR_WIDTH  (AW),
        .LOCK_READ_VALUE (8'hFF)
    ) dut (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .exec_i (exec_i),
        .bus    (arb_if)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous 512x32 RAM with byte enables, read data one clock after address
    logic [31:0] mem [512] = '{default: 32'h0};
    logic [31:0] rd_q = 32'h0;
    always @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (arb_if.ram_wen_o[b]) mem[arb_if.ram_addr_o][b*8 +: 8] <= arb_if.ram_wd_o[b*8 +: 8];
        end
        rd_q <= mem[arb_if.ram_addr_o];
    end
    assign arb_if.ram_rd_i = rd_q;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t        dp_q[$];
    exp_t        wb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  shadow [2048];
    bit          m_last_wb;
    logic [8:0]  probe_addr;
    logic [3:0]  probe_wen;
    logic [31:0] probe_wd;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: byte-array buffer, one access at a time in grant order
    task automatic model_dp(input bit we, input logic [10:0] a, input logic [7:0] d, input bit lock);
        exp_t e;
        e.err = lock;
        e.chk = !we;
        if (lock) begin
            e.data = 32'h0000_00FF;
        end else begin
            if (we) shadow[a] = d;
            e.data = {24'h0, shadow[a]};
        end
        dp_q.push_back(e);
        m_last_wb = 1'b0;
    endtask

    task automatic model_wb(input bit we, input logic [8:0] wa, input logic [3:0] sel,
                            input logic [31:0] wd);
        exp_t e;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) shadow[wa*4 + b] = wd[b*8 +: 8];
            end
        end
        e.err  = 1'b0;
        e.chk  = !we;
        e.data = {shadow[wa*4+3], shadow[wa*4+2], shadow[wa*4+1], shadow[wa*4]};
        wb_q.push_back(e);
        m_last_wb = 1'b1;
    endtask

    function automatic logic [31:0] shadow_word(input int wa);
        return {shadow[wa*4+3], shadow[wa*4+2], shadow[wa*4+1], shadow[wa*4]};
    endfunction

    // Monitor: pops an expectation for every ack the DUT presents
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (nrst_i === 1'b1 && arb_if.dp_ack_o === 1'b1) begin
                if (dp_q.size() == 0) begin
                    check_eq("dp_unexpected_ack", 32'h1, 32'h0);
                end else begin
                    e = dp_q.pop_front();
                    check_eq("dp_err", {31'h0, arb_if.dp_err_o}, {31'h0, e.err});
                    if (e.chk) check_eq("dp_rdata", {24'h0, arb_if.dp_data_o}, e.data);
                end
            end
            if (nrst_i === 1'b1 && arb_if.wb_ack_o === 1'b1) begin
                if (wb_q.size() == 0) begin
                    check_eq("wb_unexpected_ack", 32'h1, 32'h0);
                end else begin
                    e = wb_q.pop_front();
                    if (e.chk) check_eq("wb_rdata", arb_if.wb_dat_o, e.data);
                end
            end
        end
    end

    task automatic drop_reqs();
        arb_if.dp_req_i = 1'b0;
        arb_if.wb_cyc_i = 1'b0;
        arb_if.wb_stb_i = 1'b0;
    endtask

    // Holds each request until its ack is seen, then releases it on the next edge
    task automatic wait_acks(input bit need_dp, input bit need_wb, output int first_n);
        bit dp_got, wb_got, dp_now, wb_now;
        dp_got  = !need_dp;
        wb_got  = !need_wb;
        first_n = 0;
        for (int n = 1; n <= 20; n++) begin
            if (dp_got && wb_got) break;
            @(negedge clk_i);
            dp_now = arb_if.dp_ack_o;
            wb_now = arb_if.wb_ack_o;
            if ((dp_now || wb_now) && first_n == 0) first_n = n;
            @(posedge clk_i);
            #1;
            if (dp_now) begin
                arb_if.dp_req_i = 1'b0;
                dp_got = 1'b1;
            end
            if (wb_now) begin
                arb_if.wb_cyc_i = 1'b0;
                arb_if.wb_stb_i = 1'b0;
                wb_got = 1'b1;
            end
        end
        if (!(dp_got && wb_got)) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got dp=%0b wb=%0b expected dp=1 wb=1", dp_got, wb_got);
            drop_reqs();
        end
    endtask

    // Issues up to one request per side together; exec switches from e0 to e1
    // right after the first grant is sampled.
    task automatic do_batch(input bit dp_on, input bit dp_we, input logic [10:0] dp_a,
                            input logic [7:0] dp_d, input bit wb_on, input bit wb_we,
                            input logic [8:0] wa, input logic [3:0] sel, input logic [31:0] wd,
                            input bit e0, input bit e1, output int first_n);
        bit dp_first;
        dp_first = dp_on && (!wb_on || m_last_wb);
        if (dp_first) begin
            model_dp(dp_we, dp_a, dp_d, e0);
            if (wb_on) model_wb(wb_we, wa, sel, wd);
        end else if (wb_on) begin
            model_wb(wb_we, wa, sel, wd);
            if (dp_on) model_dp(dp_we, dp_a, dp_d, e1);
        end
        @(negedge clk_i);
        exec_i           = e0;
        arb_if.dp_req_i  = dp_on;
        arb_if.dp_we_i   = dp_we;
        arb_if.dp_addr_i = dp_a;
        arb_if.dp_data_i = dp_d;
        arb_if.wb_cyc_i  = wb_on;
        arb_if.wb_stb_i  = wb_on;
        arb_if.wb_we_i   = wb_we;
        arb_if.wb_adr_i  = wa;
        arb_if.wb_sel_i  = sel;
        arb_if.wb_dat_i  = wd;
        @(posedge clk_i);
        #1;
        probe_addr = arb_if.ram_addr_o;
        probe_wen  = arb_if.ram_wen_o;
        probe_wd   = arb_if.ram_wd_o;
        exec_i     = e1;
        wait_acks(dp_on, wb_on, first_n);
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        nrst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        nrst_i    = 1'b1;
        m_last_wb = 1'b1;
    endtask

    initial begin
        int fn;
        int last_n;
        int acks;
        bit side;
        bit exp_side;

        for (int i = 0; i < 2048; i++) shadow[i] = 8'h00;
        m_last_wb = 1'b1;
        nrst_i    = 1'b0;
        exec_i    = 1'b0;
        drop_reqs();
        arb_if.dp_we_i   = 1'b0;
        arb_if.dp_addr_i = '0;
        arb_if.dp_data_i = 8'h00;
        arb_if.wb_we_i   = 1'b0;
        arb_if.wb_adr_i  = '0;
        arb_if.wb_sel_i  = 4'h0;
        arb_if.wb_dat_i  = 32'h0;

        // Reset state
        #12;
        check_eq("rst_dp_ack", {31'h0, arb_if.dp_ack_o}, 32'h0);
        check_eq("rst_dp_err", {31'h0, arb_if.dp_err_o}, 32'h0);
        check_eq("rst_wb_ack", {31'h0, arb_if.wb_ack_o}, 32'h0);
        check_eq("rst_wen", {28'h0, arb_if.ram_wen_o}, 32'h0);
        check_eq("rst_addr", {23'h0, arb_if.ram_addr_o}, 32'h0);
        check_eq("rst_wd", arb_if.ram_wd_o, 32'h0);
        check_eq("rst_dp_data", {24'h0, arb_if.dp_data_o}, 32'h0);
        check_eq("rst_wb_dat", arb_if.wb_dat_o, 32'h0);
        @(negedge clk_i);
        nrst_i = 1'b1;

        // 1: DP byte write, then read back
        do_batch(1, 1, 11'h013, 8'hA5, 0, 0, 9'h0, 4'h0, 32'h0, 0, 0, fn);
        check_eq("t1_addr", {23'h0, probe_addr}, 32'h4);
        check_eq("t1_wen", {28'h0, probe_wen}, 32'h8);
        check_eq("t1_wd", probe_wd, 32'hA5A5_A5A5);
        check_eq("t1_ack_cycle", fn, 2);
        do_batch(1, 0, 11'h013, 8'h00, 0, 0, 9'h0, 4'h0, 32'h0, 0, 0, fn);

        // 2: WB word write, DP byte reads are little endian
        do_batch(0, 0, 11'h0, 8'h0, 1, 1, 9'd5, 4'hF, 32'h1234_5678, 0, 0, fn);
        check_eq("t2_wen", {28'h0, probe_wen}, 32'hF);
        for (int i = 0; i < 4; i++) begin
            do_batch(1, 0, 11'(20 + i), 8'h00, 0, 0, 9'h0, 4'h0, 32'h0, 0, 0, fn);
        end

        // 4: lock rejects DP, leaves WB alone
        do_batch(0, 0, 11'h0, 8'h0, 1, 1, 9'd0, 4'hF, 32'hCAFE_F00D, 0, 0, fn);
        do_batch(1, 1, 11'h000, 8'h55, 0, 0, 9'h0, 4'h0, 32'h0, 1, 1, fn);
        check_eq("t4_locked_wen", {28'h0, probe_wen}, 32'h0);
        do_batch(1, 0, 11'h000, 8'h00, 0, 0, 9'h0, 4'h0, 32'h0, 1, 1, fn);
        do_batch(0, 0, 11'h0, 8'h0, 1, 0, 9'd0, 4'h0, 32'h0, 1, 1, fn);

        // 6: partial byte strobes, and sel=0 write still acks without writing
        do_batch(0, 0, 11'h0, 8'h0, 1, 1, 9'd2, 4'hF, 32'hAABB_CCDD, 0, 0, fn);
        do_batch(0, 0, 11'h0, 8'h0, 1, 1, 9'd2, 4'b0011, 32'h1122_3344, 0, 0, fn);
        do_batch(0, 0, 11'h0, 8'h0, 1, 1, 9'd2, 4'b0000, 32'h9999_9999, 0, 0, fn);
        check_eq("t6_sel0_wen", {28'h0, probe_wen}, 32'h0);
        do_batch(0, 0, 11'h0, 8'h0, 1, 0, 9'd2, 4'h0, 32'h0, 0, 0, fn);
        check_eq("t6_model_word", shadow_word(2), 32'hAABB_3344);

        // 5: reset during ACCESS of a WB write aborts it
        do_batch(0, 0, 11'h0, 8'h0, 1, 1, 9'd7, 4'hF, 32'h0102_0304, 0, 0, fn);
        @(negedge clk_i);
        arb_if.wb_cyc_i = 1'b1;
        arb_if.wb_stb_i = 1'b1;
        arb_if.wb_we_i  = 1'b1;
        arb_if.wb_adr_i = 9'd7;
        arb_if.wb_sel_i = 4'hF;
        arb_if.wb_dat_i = 32'hDEAD_BEEF;
        @(posedge clk_i);
        #1;
        check_eq("t5_wen_access", {28'h0, arb_if.ram_wen_o}, 32'hF);
        #2;
        nrst_i = 1'b0;
        #1;
        check_eq("t5_wen_in_reset", {28'h0, arb_if.ram_wen_o}, 32'h0);
        check_eq("t5_ack_in_reset", {31'h0, arb_if.wb_ack_o}, 32'h0);
        repeat (2) @(negedge clk_i);
        check_eq("t5_word_kept", mem[7], 32'h0102_0304);
        nrst_i    = 1'b1;
        m_last_wb = 1'b1;
        model_wb(1, 9'd7, 4'hF, 32'hDEAD_BEEF);
        wait_acks(0, 1, fn);
        do_batch(0, 0, 11'h0, 8'h0, 1, 0, 9'd7, 4'h0, 32'h0, 0, 0, fn);

        // 3: both sides request continuously out of reset -> DP,WB,DP,WB...
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (m_last_wb) model_dp(0, 11'h014, 8'h00, 0);
            else           model_wb(0, 9'd2, 4'h0, 32'h0);
        end
        @(negedge clk_i);
        exec_i           = 1'b0;
        arb_if.dp_we_i   = 1'b0;
        arb_if.dp_addr_i = 11'h014;
        arb_if.wb_we_i   = 1'b0;
        arb_if.wb_adr_i  = 9'd2;
        arb_if.dp_req_i  = 1'b1;
        arb_if.wb_cyc_i  = 1'b1;
        arb_if.wb_stb_i  = 1'b1;
        acks   = 0;
        last_n = 0;
        for (int n = 1; n <= 40 && acks < 8; n++) begin
            @(negedge clk_i);
            if (arb_if.dp_ack_o || arb_if.wb_ack_o) begin
                side     = arb_if.wb_ack_o;
                exp_side = acks[0];
                check_eq("t3_order", {31'h0, side}, {31'h0, exp_side});
                if (acks > 0) check_eq("t3_spacing", n - last_n, 3);
                last_n = n;
                acks++;
            end
        end
        @(posedge clk_i);
        #1;
        drop_reqs();
        check_eq("t3_ack_count", acks, 8);
        dp_q.delete();
        wb_q.delete();
        repeat (4) @(negedge clk_i);

        // Randomised mixed traffic with lock changes between grants
        for (int i = 0; i < 80; i++) begin
            bit dp_on, wb_on;
            dp_on = 1'($urandom_range(0, 1));
            wb_on = dp_on ? 1'($urandom_range(0, 1)) : 1'b1;
            do_batch(dp_on, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 63)),
                     8'($urandom), wb_on, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)),
                     4'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), fn);
        end

        repeat (4) @(negedge clk_i);
        check_eq("dp_queue_empty", dp_q.size(), 0);
        check_eq("wb_queue_empty", wb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
